ota_offset_cal_ctrl: RTL

- Digital sequencer for the fully differential folded-cascode OTA (vinp/vinn in, voutp/voutn out).
- Powers up the bias network, shorts the inputs, then runs a successive-approximation (SAR) search on an offset-trim DAC code. The search uses a latched comparator that senses the sign of voutp-voutn.
- Releases the amplifier for normal operation once the search completes.
- Sits beside the OTA in the analog macro's digital wrapper; re-triggerable for recalibration.

---
 rtl/ota_offset_cal_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ota_offset_cal_ctrl.sv
// rtl/ota_offset_cal_ctrl.sv - OTA bias power-up and SAR offset-trim calibration sequencer
module ota_offset_cal_ctrl #(
  parameter int TRIM_W      = 6,
  parameter int BIAS_SETTLE = 64,
  parameter int SETTLE_CYC  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              start,
  input  logic              cmp_out,
  output logic              bias_en,
  output logic              short_in,
  output logic [TRIM_W-1:0] trim_code,
  output logic              busy,
  output logic              done,
  output logic              amp_ready,
  output logic              cal_err
);

  localparam int CNT_MAX = (BIAS_SETTLE > SETTLE_CYC) ? BIAS_SETTLE : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] MIDSCALE = TRIM_W'(1) << (TRIM_W - 1);
  localparam logic [TRIM_W-1:0] ALL_ONES = {TRIM_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, BIAS_UP, SHORT, SAR_SET, SAR_WAIT, FINISH, RUN
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nx;
  logic [TRIM_W-1:0]  trim_nx;
  logic               cal_err_nx;
  logic               cmp_meta, cmp_s;
  logic               bias_nx, short_nx, busy_nx, done_nx, ready_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    trim_nx    = trim_code;
    cal_err_nx = cal_err;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          state_nx   = BIAS_UP;
          cal_err_nx = 1'b0;
        end
      end
      BIAS_UP: begin
        if (cnt == CNT_W'(BIAS_SETTLE - 1)) begin
          state_nx   = SHORT;
          cnt_nx     = '0;
          trim_nx    = '0;
          bit_idx_nx = IDX_W'(TRIM_W - 1);
        end
      end
      SHORT: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          state_nx = SAR_SET;
          cnt_nx   = '0;
        end
      end
      SAR_SET: begin
        trim_nx[bit_idx] = 1'b1;
        state_nx         = SAR_WAIT;
        cnt_nx           = '0;
      end
      SAR_WAIT: begin
        // Two synchronizer stages fit inside the wait, so cmp_s here reflects the new code
        if (cnt == CNT_W'(SETTLE_CYC - 2)) begin
          cnt_nx = '0;
          if (!cmp_s) trim_nx[bit_idx] = 1'b0;
          if (bit_idx == '0) begin
            state_nx = FINISH;
          end else begin
            bit_idx_nx = bit_idx - 1'b1;
            state_nx   = SAR_SET;
          end
        end
      end
      FINISH: begin
        cnt_nx     = '0;
        cal_err_nx = (trim_code == '0) || (trim_code == ALL_ONES);
        state_nx   = RUN;
      end
      RUN: begin
        cnt_nx = '0;
        if (start) begin
          state_nx   = BIAS_UP;
          cal_err_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    bias_nx  = (state != IDLE);
    short_nx = (state == SHORT) || (state == SAR_SET) || (state == SAR_WAIT);
    busy_nx  = short_nx || (state == BIAS_UP);
    done_nx  = (state == FINISH);
    ready_nx = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp_out;
      cmp_s    <= cmp_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      trim_code <= MIDSCALE;
      cal_err   <= 1'b0;
      bias_en   <= 1'b0;
      short_in  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      amp_ready <= 1'b0;
    end else if (!en) begin
      // Power-down keeps the partial trim code and the error flag for inspection
      state     <= IDLE;
      cnt       <= '0;
      bias_en   <= 1'b0;
      short_in  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      amp_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      trim_code <= trim_nx;
      cal_err   <= cal_err_nx;
      bias_en   <= bias_nx;
      short_in  <= short_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      amp_ready <= ready_nx;
    end
  end

endmodule
